// File: rtl/mv_result_drain.sv
// Streams MV result words out of the vector BRAM result region onto an AXI-Stream master.
// A 2-entry output FIFO absorbs the 1-cycle BRAM read latency so the stream runs at 1 beat/cycle.
module mv_result_drain #(
    parameter int                DATA_W    = 36,
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 10'h200
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [8:0]        width,
    output logic              busy,
    output logic              done,
    output logic              bram_clk,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              state_reg, state_next;
    logic [8:0]          width_reg;
    logic [9:0]          iss_rows_reg;
    logic [6:0]          iss_cnt_reg;
    logic [6:0]          beat_cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                inflight_reg;
    logic [1:0]          occ_reg;
    logic [DATA_W-1:0]   head_reg;
    logic [DATA_W-1:0]   tail_reg;

    logic                start_ok;
    logic                pop;
    logic                push;
    logic [2:0]          credit;
    logic                rd_issue;
    logic                last_issue;

    assign start_ok   = (state_reg == S_IDLE) && start;
    assign m_tvalid   = (occ_reg != 2'd0);
    assign pop        = m_tvalid && m_tready;
    assign push       = inflight_reg;
    assign credit     = {1'b0, occ_reg} + {2'b00, inflight_reg};
    // A beat leaving this cycle frees its slot in time for the read issued now.
    assign rd_issue   = (state_reg == S_READ) && ((credit < 3'd2) || ((credit == 3'd2) && pop));
    assign last_issue = rd_issue && ((iss_rows_reg + 10'd6) >= {1'b0, width_reg});

    // Only in DRAIN is the total word count final, so the beat counter can mark the last beat.
    assign m_tlast    = m_tvalid && (state_reg == S_DRAIN) && (beat_cnt_reg == (iss_cnt_reg - 7'd1));
    assign m_tdata    = head_reg;
    assign bram_addr  = addr_reg;
    assign bram_clk   = clk;
    assign bram_we    = 1'b0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = (width != 9'd0) ? S_READ : S_DONE;
            S_READ:  if (last_issue) state_next = S_DRAIN;
            S_DRAIN: if (pop && m_tlast) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_reg != S_IDLE);
        done    = (state_reg == S_DONE);
        bram_en = rd_issue;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            width_reg    <= '0;
            iss_rows_reg <= '0;
            iss_cnt_reg  <= '0;
            beat_cnt_reg <= '0;
            addr_reg     <= BASE_ADDR;
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= rd_issue;
            if (start_ok) begin
                width_reg    <= width;
                iss_rows_reg <= '0;
                iss_cnt_reg  <= '0;
                beat_cnt_reg <= '0;
                addr_reg     <= BASE_ADDR;
            end else begin
                if (rd_issue) begin
                    iss_rows_reg <= iss_rows_reg + 10'd6;
                    iss_cnt_reg  <= iss_cnt_reg + 7'd1;
                    addr_reg     <= addr_reg + 1'b1;
                end
                if (pop) begin
                    beat_cnt_reg <= beat_cnt_reg + 7'd1;
                end
                if (state_next == S_DONE) begin
                    addr_reg <= BASE_ADDR;
                end
            end
        end
    end

    // Output FIFO: head_reg drives the stream, tail_reg holds the second entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ_reg  <= 2'd0;
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (occ_reg == 2'd1) begin
                        head_reg <= bram_dout;
                    end else begin
                        head_reg <= tail_reg;
                        tail_reg <= bram_dout;
                    end
                end
                2'b10: begin
                    if (occ_reg == 2'd0) begin
                        head_reg <= bram_dout;
                    end else begin
                        tail_reg <= bram_dout;
                    end
                    occ_reg <= occ_reg + 2'd1;
                end
                2'b01: begin
                    head_reg <= tail_reg;
                    occ_reg  <= occ_reg - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
